// File: rtl/packet_handler_hls_deadlock_report_ctrl_if.sv
// rtl/packet_handler_hls_deadlock_report_ctrl_if.sv - port bundle for the deadlock report controller
//
// Purpose: groups the detect-unit broadcast signals and the latched report
// signals of packet_handler_hls_deadlock_report_ctrl into one interface.
// Optional build macro: PACKET_HANDLER_DL_REPORT_CNT_EN adds dl_count.
//
// Signals:
//   dl_detect_vec      units -> ctrl  per-process dl_detect_out
//   token_ret_vec      units -> ctrl  token present at process i
//   report_ack         sw    -> ctrl  single-cycle report acknowledge
//   dl_detect_glb      ctrl  -> units global dl_detect_in broadcast
//   origin_vec         ctrl  -> units one-hot origin strobe
//   token_clear        ctrl  -> units token clear broadcast
//   deadlock_valid     ctrl  -> sw    report valid, held until ack
//   deadlock_proc_id   ctrl  -> sw    origin process index
//   deadlock_proc_vec  ctrl  -> sw    processes visited by the token
//   timeout_err        ctrl  -> sw    sticky trace-timeout flag
//   dl_count           ctrl  -> sw    saturating report count (optional)
//
// Modports: slave = controller side, master = environment driving it.

interface packet_handler_hls_deadlock_report_ctrl_if #(
  parameter int PROC_NUM = 4
);
  localparam int ID_W = $clog2(PROC_NUM);

  logic [PROC_NUM-1:0] dl_detect_vec;
  logic [PROC_NUM-1:0] token_ret_vec;
  logic                report_ack;
  logic                dl_detect_glb;
  logic [PROC_NUM-1:0] origin_vec;
  logic                token_clear;
  logic                deadlock_valid;
  logic [ID_W-1:0]     deadlock_proc_id;
  logic [PROC_NUM-1:0] deadlock_proc_vec;
  logic                timeout_err;
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
  logic [15:0]         dl_count;
`endif

  modport slave (
    input  dl_detect_vec, token_ret_vec, report_ack,
    output dl_detect_glb, origin_vec, token_clear, deadlock_valid,
           deadlock_proc_id, deadlock_proc_vec, timeout_err
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
    , output dl_count
`endif
  );

  modport master (
    output dl_detect_vec, token_ret_vec, report_ack,
    input  dl_detect_glb, origin_vec, token_clear, deadlock_valid,
           deadlock_proc_id, deadlock_proc_vec, timeout_err
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
    , input dl_count
`endif
  );

endinterface

// File: rtl/packet_handler_hls_deadlock_report_ctrl.sv
// rtl/packet_handler_hls_deadlock_report_ctrl.sv - central deadlock confirm/trace/report controller
//
// Purpose: collects the per-process deadlock detect outputs, confirms that
// the elected (lowest-index) unit keeps detecting, strobes it as origin,
// broadcasts the global detect, follows the token around the dependence
// cycle and latches a report that is held until acknowledged.
// Optional build macro: PACKET_HANDLER_DL_REPORT_CNT_EN adds the saturating
// dl_count report counter.
//
// Ports:
//   clock  clock
//   reset  asynchronous active-low reset
//   bus    packet_handler_hls_deadlock_report_ctrl_if.slave (see interface file)

module packet_handler_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TIMEOUT_W      = 8
) (
  input logic clock,
  input logic reset,
  packet_handler_hls_deadlock_report_ctrl_if.slave bus
);

  localparam int ID_W  = $clog2(PROC_NUM);
  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIRM,
    S_ORIGIN,
    S_TRACE,
    S_REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [PROC_NUM-1:0]  proc_vec_q, proc_vec_d;
  logic [ID_W-1:0]      rep_id_q, rep_id_d;
  logic [PROC_NUM-1:0]  rep_vec_q, rep_vec_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [ID_W-1:0]      low_idx;
  logic                 sel_det;
  logic                 dl_glb;
  logic [PROC_NUM-1:0]  origin;
  logic                 tclr;
  logic                 rep_valid;
  logic                 report_done;

  // Lowest set detect bit wins the election.
  always_comb begin
    low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (bus.dl_detect_vec[i]) low_idx = ID_W'(i);
    end
  end

  assign sel_det = bus.dl_detect_vec[sel_q];

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    proc_vec_d    = proc_vec_q;
    rep_id_d      = rep_id_q;
    rep_vec_d     = rep_vec_q;
    timeout_err_d = timeout_err_q;
    dl_glb        = 1'b0;
    origin        = '0;
    tclr          = 1'b0;
    rep_valid     = 1'b0;
    report_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.dl_detect_vec) begin
          sel_d   = low_idx;
          cnt_d   = CNT_W'(1);
          state_d = (CONFIRM_CYCLES == 1) ? S_ORIGIN : S_CONFIRM;
        end
      end

      S_CONFIRM: begin
        // Only the elected unit matters; other bits may come and go.
        if (!sel_det) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(CONFIRM_CYCLES)) begin
          state_d = S_ORIGIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ORIGIN: begin
        dl_glb     = 1'b1;
        origin     = PROC_NUM'(1) << sel_q;
        proc_vec_d = PROC_NUM'(1) << sel_q;
        timer_d    = '0;
        state_d    = S_TRACE;
      end

      S_TRACE: begin
        dl_glb     = 1'b1;
        proc_vec_d = proc_vec_q | bus.token_ret_vec;
        // The origin re-detecting means the token has come full circle.
        if (sel_det) begin
          tclr        = 1'b1;
          rep_id_d    = sel_q;
          rep_vec_d   = proc_vec_q | bus.token_ret_vec;
          report_done = 1'b1;
          state_d     = S_REPORT;
        end else if (&timer_q) begin
          tclr          = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end

      S_REPORT: begin
        // Global detect stays high so units remain frozen while reported.
        dl_glb    = 1'b1;
        rep_valid = 1'b1;
        if (bus.report_ack) begin
          rep_id_d  = '0;
          rep_vec_d = '0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      proc_vec_q    <= '0;
      rep_id_q      <= '0;
      rep_vec_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      proc_vec_q    <= proc_vec_d;
      rep_id_q      <= rep_id_d;
      rep_vec_q     <= rep_vec_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.dl_detect_glb     = dl_glb;
  assign bus.origin_vec        = origin;
  assign bus.token_clear       = tclr;
  assign bus.deadlock_valid    = rep_valid;
  assign bus.deadlock_proc_id  = rep_id_q;
  assign bus.deadlock_proc_vec = rep_vec_q;
  assign bus.timeout_err       = timeout_err_q;

`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
  logic [15:0] dl_count_q, dl_count_d;

  always_comb begin
    dl_count_d = dl_count_q;
    if (report_done && (dl_count_q != 16'hFFFF)) dl_count_d = dl_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dl_count_q <= '0;
    else        dl_count_q <= dl_count_d;
  end

  assign bus.dl_count = dl_count_q;
`else
  logic unused_report_done;
  assign unused_report_done = report_done;
`endif

endmodule

// File: tb/tb_packet_handler_hls_deadlock_report_ctrl.sv
// tb/tb_packet_handler_hls_deadlock_report_ctrl.sv - self-checking bench for the deadlock report controller

module tb_packet_handler_hls_deadlock_report_ctrl;

  localparam int P    = 4;
  localparam int C    = 4;
  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  packet_handler_hls_deadlock_report_ctrl_if #(.PROC_NUM(P)) bus_if ();

  packet_handler_hls_deadlock_report_ctrl #(
    .PROC_NUM(P), .CONFIRM_CYCLES(C), .TIMEOUT_W(TW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus_if.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // sampled DUT outputs
  logic       s_glb, s_tclr, s_valid, s_terr;
  logic [3:0] s_org, s_pvec;
  logic [1:0] s_id;
  logic [15:0] s_cnt;

  // behavioural model: phase 0 idle, 1 confirm, 2 origin, 3 trace, 4 report
  int         m_ph, m_sel, m_run, m_tr, m_rid, m_count;
  logic [3:0] m_vis, m_rvec;
  bit         m_terr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < P; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    m_ph = 0; m_sel = 0; m_run = 0; m_tr = 0; m_rid = 0; m_count = 0;
    m_vis = '0; m_rvec = '0; m_terr = 0;
  endtask

  task automatic model_check(input logic [3:0] det);
    logic [3:0] e_org;
    if (!reset) model_clear();
    e_org = (m_ph == 2) ? 4'(1 << m_sel) : 4'b0;
    chk("glb",   32'(s_glb),   32'(m_ph >= 2));
    chk("org",   32'(s_org),   32'(e_org));
    chk("tclr",  32'(s_tclr),  32'(m_ph == 3 && (det[m_sel] || m_tr == TMAX)));
    chk("valid", 32'(s_valid), 32'(m_ph == 4));
    chk("id",    32'(s_id),    (m_ph == 4) ? 32'(m_rid) : 32'd0);
    chk("pvec",  32'(s_pvec),  (m_ph == 4) ? 32'(m_rvec) : 32'd0);
    chk("terr",  32'(s_terr),  32'(m_terr));
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
    chk("count", 32'(s_cnt),   32'(m_count));
`endif
  endtask

  task automatic model_step(input logic [3:0] det, input logic [3:0] tok, input logic ack);
    case (m_ph)
      0: if (det != 0) begin m_sel = lowest(det); m_run = 1; m_ph = (C == 1) ? 2 : 1; end
      1: if (!det[m_sel]) m_ph = 0;
         else if (m_run == C) m_ph = 2;
         else m_run++;
      2: begin m_vis = 4'(1 << m_sel); m_tr = 0; m_ph = 3; end
      3: begin
        if (det[m_sel]) begin
          m_rid = m_sel; m_rvec = m_vis | tok; m_ph = 4;
          if (m_count < 65535) m_count++;
        end else if (m_tr == TMAX) begin
          m_terr = 1; m_ph = 0;
        end else m_tr++;
        m_vis = m_vis | tok;
      end
      4: if (ack) m_ph = 0;
      default: m_ph = 0;
    endcase
  endtask

  // Drive one cycle of inputs, sample at the falling edge, check vs model.
  task automatic cyc(input logic [3:0] det, input logic [3:0] tok, input logic ack);
    bus_if.dl_detect_vec = det;
    bus_if.token_ret_vec = tok;
    bus_if.report_ack    = ack;
    @(negedge clock);
    s_glb = bus_if.dl_detect_glb;  s_org  = bus_if.origin_vec;
    s_tclr = bus_if.token_clear;   s_valid = bus_if.deadlock_valid;
    s_id = bus_if.deadlock_proc_id; s_pvec = bus_if.deadlock_proc_vec;
    s_terr = bus_if.timeout_err;
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
    s_cnt = bus_if.dl_count;
`else
    s_cnt = '0;
`endif
    model_check(det);
    if (reset) model_step(det, tok, ack);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0] det, tok;
    logic       ack;
    logic       glb;
    logic [3:0] org;
    logic       tclr, valid;
    logic [1:0] id;
    logic [3:0] pvec;
    logic       terr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] det, tok, input logic ack, glb, input logic [3:0] org,
                     input logic tclr, valid, input logic [1:0] id, input logic [3:0] pvec,
                     input logic terr);
    vec_t v;
    v.det = det; v.tok = tok; v.ack = ack; v.glb = glb; v.org = org;
    v.tclr = tclr; v.valid = valid; v.id = id; v.pvec = pvec; v.terr = terr;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] r_det;
    model_clear();
    bus_if.dl_detect_vec = '0; bus_if.token_ret_vec = '0; bus_if.report_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    // reset state
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("rst_glb", 32'(s_glb), 0);
    chk("rst_terr", 32'(s_terr), 0);
    reset = 1'b1;

    // basic confirm + trace/report, then priority/glitch re-election
    //  det      tok      ack   glb  org      tclr  val  id     pvec     terr
    for (int i = 0; i < 5; i++)
      add(4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 1, 4'b0100, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b1000, 0, 1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b0001, 0, 1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0100, 4'b0000, 0, 1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 1, 2'd2, 4'b1101, 0);
    add(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 1, 2'd2, 4'b1101, 0);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b1010, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    for (int i = 0; i < 5; i++)
      add(4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 1, 4'b1000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b1000, 4'b0000, 0, 1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    add(4'b0001, 4'b0000, 1, 1, 4'b0000, 0, 1, 2'd3, 4'b1000, 0);
    add(4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].det, tbl[i].tok, tbl[i].ack);
      chk($sformatf("tbl%0d_glb", i),   32'(s_glb),   32'(tbl[i].glb));
      chk($sformatf("tbl%0d_org", i),   32'(s_org),   32'(tbl[i].org));
      chk($sformatf("tbl%0d_tclr", i),  32'(s_tclr),  32'(tbl[i].tclr));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_id", i),    32'(s_id),    32'(tbl[i].id));
      chk($sformatf("tbl%0d_pvec", i),  32'(s_pvec),  32'(tbl[i].pvec));
      chk($sformatf("tbl%0d_terr", i),  32'(s_terr),  32'(tbl[i].terr));
    end
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
    chk("count_two", 32'(s_cnt), 32'd2);
`endif

    // ack with simultaneous detection: detection must wait for IDLE
    for (int i = 0; i < 5; i++) cyc(4'b0010, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("ackseq_org", 32'(s_org), 32'b0010);
    cyc(4'b0010, 4'b0000, 1'b0);
    chk("ackseq_tclr", 32'(s_tclr), 1);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("ackseq_valid", 32'(s_valid), 1);
    cyc(4'b0001, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0000, 1'b0);
    chk("ackseq_cleared", 32'(s_valid), 0);
    chk("ackseq_pvec_clr", 32'(s_pvec), 0);
    for (int i = 0; i < 3; i++) cyc(4'b0001, 4'b0000, 1'b0);
    cyc(4'b0001, 4'b0000, 1'b0);
    chk("ackseq_no_early_org", 32'(s_org), 0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("ackseq_late_org", 32'(s_org), 32'b0001);
    cyc(4'b0001, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b0);
`ifdef PACKET_HANDLER_DL_REPORT_CNT_EN
    chk("count_four", 32'(s_cnt), 32'd4);
`endif

    // trace timeout: elected unit 3 never re-detects; other bits ignored
    for (int i = 0; i < 5; i++) cyc(4'b1000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("to_org", 32'(s_org), 32'b1000);
    for (int k = 0; k <= TMAX; k++) begin
      cyc(4'b0111, 4'b0010, 1'b0);
      chk($sformatf("to_tclr%0d", k), 32'(s_tclr), 32'(k == TMAX));
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("to_terr", 32'(s_terr), 1);
    chk("to_glb", 32'(s_glb), 0);
    chk("to_valid", 32'(s_valid), 0);

    // reset in the middle of a trace
    for (int i = 0; i < 5; i++) cyc(4'b0100, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0100, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("mid_glb", 32'(s_glb), 1);
    reset = 1'b0;
    cyc(4'b0100, 4'b0000, 1'b0);
    chk("rst_mid_tclr", 32'(s_tclr), 0);
    chk("rst_mid_glb", 32'(s_glb), 0);
    chk("rst_mid_terr", 32'(s_terr), 0);
    reset = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("rst_after_glb", 32'(s_glb), 0);

    // randomized traffic against the model
    r_det = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) r_det = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc(r_det, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0, ($urandom_range(0, 3) == 0));
    end
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
